// File: rtl/axi_ram_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite RAM front-end.
package axi_ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_ISSUE, W_RESP
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE, R_ISSUE, R_WAIT, R_RESP
  } rstate_e;

endpackage

// File: rtl/axi_lite_ram_ctrl.sv
// AXI4-Lite slave that turns byte-addressed reads/writes into single-cycle Simple_RAM accesses.
// Define AXI_RAM_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_ram_ctrl
  import axi_ram_pkg::*;
#(
  parameter int NUM_SLOTS        = 5,
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int AXI_ADDR_WIDTH   = 32,
  localparam int DATA_WIDTH_BITS = 8 * DATA_WIDTH_BYTES,
  localparam int ADDR_WIDTH_BITS = $clog2(NUM_SLOTS),
  localparam int BYTE_OFS        = $clog2(DATA_WIDTH_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [DATA_WIDTH_BITS-1:0]  s_axi_wdata,
  input  logic [DATA_WIDTH_BYTES-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [DATA_WIDTH_BITS-1:0]  s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        ram_w_en,
  output logic [ADDR_WIDTH_BITS-1:0]  ram_w_addr,
  output logic [DATA_WIDTH_BITS-1:0]  ram_w_data,
  output logic [DATA_WIDTH_BYTES-1:0] ram_w_strb,
  output logic                        ram_r_en,
  output logic [ADDR_WIDTH_BITS-1:0]  ram_r_addr,
  input  logic [DATA_WIDTH_BITS-1:0]  ram_r_data
);

`ifdef AXI_RAM_ERR_RESP_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  function automatic logic in_rng(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> BYTE_OFS) < AXI_ADDR_WIDTH'(NUM_SLOTS);
  endfunction

  function automatic logic [ADDR_WIDTH_BITS-1:0] idx_of(input logic [AXI_ADDR_WIDTH-1:0] a);
    return ADDR_WIDTH_BITS'(a >> BYTE_OFS);
  endfunction

  // ---------------- write path ----------------
  wstate_e                     wstate_q;
  logic                        awready_q, wready_q, bvalid_q, wr_oor_q;
  logic [1:0]                  bresp_q;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, waddr_d;
  logic [DATA_WIDTH_BITS-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH_BYTES-1:0] wstrb_q, wstrb_d;
  logic                        ram_w_en_q;
  logic [ADDR_WIDTH_BITS-1:0]  ram_w_addr_q;
  logic [DATA_WIDTH_BITS-1:0]  ram_w_data_q;
  logic [DATA_WIDTH_BYTES-1:0] ram_w_strb_q;
  logic                        aw_hs, w_hs, go_issue;

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid  & wready_q;

  // The RAM port is loaded on the edge that completes the pair, so the
  // half arriving on that edge is taken straight from the bus.
  always_comb begin
    waddr_d  = aw_hs ? s_axi_awaddr : awaddr_q;
    wdata_d  = w_hs  ? s_axi_wdata  : wdata_q;
    wstrb_d  = w_hs  ? s_axi_wstrb  : wstrb_q;
    go_issue = 1'b0;
    case (wstate_q)
      W_IDLE:    go_issue = aw_hs & w_hs;
      W_HAVE_AW: go_issue = w_hs;
      W_HAVE_W:  go_issue = aw_hs;
      default:   go_issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q     <= W_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      wr_oor_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      ram_w_en_q   <= 1'b0;
      ram_w_addr_q <= '0;
      ram_w_data_q <= '0;
      ram_w_strb_q <= '0;
    end else begin
      ram_w_en_q <= 1'b0;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (go_issue) begin
        wr_oor_q <= ~in_rng(waddr_d);
        if (in_rng(waddr_d)) begin
          ram_w_en_q   <= 1'b1;
          ram_w_addr_q <= idx_of(waddr_d);
          ram_w_data_q <= wdata_d;
          ram_w_strb_q <= wstrb_d;
        end
      end
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          if (go_issue) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wstate_q  <= W_ISSUE;
          end else if (aw_hs) begin
            awready_q <= 1'b0;
            wstate_q  <= W_HAVE_AW;
          end else if (w_hs) begin
            wready_q  <= 1'b0;
            wstate_q  <= W_HAVE_W;
          end
        end
        W_HAVE_AW: if (w_hs) begin
          wready_q <= 1'b0;
          wstate_q <= W_ISSUE;
        end
        W_HAVE_W: if (aw_hs) begin
          awready_q <= 1'b0;
          wstate_q  <= W_ISSUE;
        end
        W_ISSUE: begin
          bvalid_q <= 1'b1;
          bresp_q  <= wr_oor_q ? OOR_RESP : RESP_OKAY;
          wstate_q <= W_RESP;
        end
        W_RESP: if (s_axi_bready) begin
          bvalid_q  <= 1'b0;
          bresp_q   <= RESP_OKAY;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          wstate_q  <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rstate_e                    rstate_q;
  logic                       arready_q, rvalid_q, rd_oor_q, ram_r_en_q;
  logic [1:0]                 rresp_q;
  logic [DATA_WIDTH_BITS-1:0] rdata_q;
  logic [ADDR_WIDTH_BITS-1:0] ram_r_addr_q;
  logic                       ar_hs;

  assign ar_hs = s_axi_arvalid & arready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q     <= R_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      rd_oor_q     <= 1'b0;
      ram_r_en_q   <= 1'b0;
      ram_r_addr_q <= '0;
    end else begin
      ram_r_en_q <= 1'b0;
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rd_oor_q  <= ~in_rng(s_axi_araddr);
            if (in_rng(s_axi_araddr)) begin
              ram_r_en_q   <= 1'b1;
              ram_r_addr_q <= idx_of(s_axi_araddr);
            end
            rstate_q <= R_ISSUE;
          end
        end
        R_ISSUE: rstate_q <= R_WAIT;
        R_WAIT: begin
          rdata_q  <= rd_oor_q ? '0 : ram_r_data;
          rresp_q  <= rd_oor_q ? OOR_RESP : RESP_OKAY;
          rvalid_q <= 1'b1;
          rstate_q <= R_RESP;
        end
        R_RESP: if (s_axi_rready) begin
          rvalid_q  <= 1'b0;
          rresp_q   <= RESP_OKAY;
          arready_q <= 1'b1;
          rstate_q  <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign ram_w_en      = ram_w_en_q;
  assign ram_w_addr    = ram_w_addr_q;
  assign ram_w_data    = ram_w_data_q;
  assign ram_w_strb    = ram_w_strb_q;
  assign ram_r_en      = ram_r_en_q;
  assign ram_r_addr    = ram_r_addr_q;

endmodule

// File: tb/tb_axi_lite_ram_ctrl.sv
// Directed + randomized bench for axi_lite_ram_ctrl with a behavioural RAM and word-array reference model.
module tb_axi_lite_ram_ctrl;

  localparam int NS = 5;
`ifdef AXI_RAM_ERR_RESP_EN
  localparam logic [1:0] ERR_EXP = 2'b10;
`else
  localparam logic [1:0] ERR_EXP = 2'b00;
`endif

  logic        clk, rst_n, ram_clr;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        ram_w_en, ram_r_en;
  logic [2:0]  ram_w_addr, ram_r_addr;
  logic [31:0] ram_w_data, ram_r_data;
  logic [3:0]  ram_w_strb;

  axi_lite_ram_ctrl #(.NUM_SLOTS(NS), .DATA_WIDTH_BYTES(4), .AXI_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_w_strb(ram_w_strb), .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr),
    .ram_r_data(ram_r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for Simple_RAM: strobed write on the edge, read data one cycle later.
  logic [31:0] mem [NS];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < NS; i++) mem[i] <= '0;
    end else begin
      if (ram_w_en)
        for (int b = 0; b < 4; b++)
          if (ram_w_strb[b]) mem[ram_w_addr][8*b +: 8] <= ram_w_data[8*b +: 8];
      if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM-port monitor
  int          wen_cnt = 0, ren_cnt = 0;
  logic [2:0]  last_w_addr;
  logic [31:0] last_w_data;
  logic [3:0]  last_w_strb;
  logic        prev_wen = 1'b0, prev_ren = 1'b0;
  always @(negedge clk) begin
    if (ram_w_en === 1'b1) begin
      wen_cnt++;
      last_w_addr = ram_w_addr;
      last_w_data = ram_w_data;
      last_w_strb = ram_w_strb;
      chk("w_en_addr_in_range", 128'(ram_w_addr < 3'(NS)), 128'd1);
      chk("w_en_single_pulse", 128'(prev_wen), 128'd0);
    end
    if (ram_r_en === 1'b1) begin
      ren_cnt++;
      chk("r_en_addr_in_range", 128'(ram_r_addr < 3'(NS)), 128'd1);
      chk("r_en_single_pulse", 128'(prev_ren), 128'd0);
    end
    prev_wen = ram_w_en;
    prev_ren = ram_r_en;
  end

  // Reference model: word array updated byte-by-byte from the strobes
  logic [31:0] exp_mem [NS];

  function automatic bit mdl_in(input logic [31:0] a);
    return (a / 4) < NS;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (mdl_in(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[a / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    return mdl_in(a) ? exp_mem[a / 4] : 32'h0;
  endfunction

  function automatic logic [1:0] mdl_resp(input logic [31:0] a);
    return mdl_in(a) ? 2'b00 : ERR_EXP;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat, output int hs_cyc);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done) && c < 50) begin
      s_axi_awvalid = !aw_done && c >= aw_dly;
      s_axi_wvalid  = !w_done  && c >= w_dly;
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid  && s_axi_wready;
      @(negedge clk);
      c++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      if (aw_done) s_axi_awvalid = 0;
      if (w_done)  s_axi_wvalid  = 0;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    hs_cyc = c;
    chk("aw_w_handshake_timeout", 128'(aw_done && w_done), 128'd1);
    lat = 1;
    while (!s_axi_bvalid && lat < 20) begin @(negedge clk); lat++; end
    chk("b_timeout", 128'(s_axi_bvalid), 128'd1);
    resp = s_axi_bresp;
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdly, output logic [31:0] d,
                          output logic [1:0] resp, output int lat, output bit stable);
    bit done = 0;
    int c = 0;
    s_axi_araddr = a;
    while (!done && c < 50) begin
      s_axi_arvalid = 1;
      done = s_axi_arready;
      @(negedge clk);
      c++;
    end
    s_axi_arvalid = 0;
    chk("ar_handshake_timeout", 128'(done), 128'd1);
    lat = 1;
    while (!s_axi_rvalid && lat < 20) begin @(negedge clk); lat++; end
    chk("r_timeout", 128'(s_axi_rvalid), 128'd1);
    d = s_axi_rdata; resp = s_axi_rresp; stable = 1;
    repeat (rdly) begin
      @(negedge clk);
      if (!s_axi_rvalid || s_axi_rdata !== d || s_axi_rresp !== resp) stable = 0;
    end
    s_axi_rready = 1;
    @(negedge clk);
    s_axi_rready = 0;
  endtask

  initial begin
    logic [1:0]  resp, resp2;
    logic [31:0] rd, rd2, wd, a;
    logic [3:0]  st;
    int          lat, lat2, hs, n0, r0;
    bit          stb, stb2, bv_seen;

    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0;
    s_axi_rready = 0;
    for (int i = 0; i < NS; i++) exp_mem[i] = '0;
    rst_n = 0; ram_clr = 1;

    // reset
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs_a", {s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
                              s_axi_arready, s_axi_rresp, s_axi_rvalid, ram_w_en, ram_r_en}, 0);
      chk("reset_outputs_b", {s_axi_rdata, ram_w_addr, ram_w_data, ram_w_strb, ram_r_addr}, 0);
    end
    ram_clr = 0; rst_n = 1;
    @(negedge clk);
    chk("readies_after_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    chk("no_en_during_reset", 128'(wen_cnt + ren_cnt), 0);

    // simultaneous AW/W
    n0 = wen_cnt;
    axi_write(32'h4, 32'h11223344, 4'b1101, 0, 0, resp, lat, hs);
    mdl_write(32'h4, 32'h11223344, 4'b1101);
    chk("sim_w_count", 128'(wen_cnt - n0), 1);
    chk("sim_w_addr", last_w_addr, 1);
    chk("sim_w_strb", last_w_strb, 4'b1101);
    chk("sim_w_data", last_w_data, 32'h11223344);
    chk("sim_w_b_latency", 128'(lat), 2);
    chk("sim_w_bresp", resp, 2'b00);

    // split write, W three cycles ahead of AW
    n0 = wen_cnt;
    axi_write(32'h4, 32'h00003300, 4'b0010, 3, 0, resp, lat, hs);
    mdl_write(32'h4, 32'h00003300, 4'b0010);
    chk("split_hs_cycles", 128'(hs), 4);
    chk("split_w_count", 128'(wen_cnt - n0), 1);
    chk("split_bresp", resp, 2'b00);
    axi_read(32'h4, 0, rd, resp, lat, stb);
    chk("split_readback", rd, 32'h11223344);
    chk("split_readback_model", rd, mdl_read(32'h4));

    // read with backpressure
    axi_read(32'h4, 5, rd, resp, lat, stb);
    chk("bp_r_latency", 128'(lat), 3);
    chk("bp_r_stable", 128'(stb), 1);
    chk("bp_r_data", rd, mdl_read(32'h4));
    chk("bp_r_resp", resp, 2'b00);

    // out of range, index 5
    n0 = wen_cnt; r0 = ren_cnt;
    axi_write(32'h14, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat, hs);
    chk("oor_no_w_en", 128'(wen_cnt - n0), 0);
    chk("oor_bresp", resp, ERR_EXP);
    chk("oor_b_latency", 128'(lat), 2);
    axi_read(32'h14, 0, rd, resp, lat, stb);
    chk("oor_no_r_en", 128'(ren_cnt - r0), 0);
    chk("oor_rresp", resp, ERR_EXP);
`ifndef AXI_RAM_ERR_RESP_EN
    chk("oor_rdata_zero", rd, 0);
`endif

    // concurrent read of 0x0 and write of 0x8
    rd2 = mdl_read(32'h0);
    fork
      axi_read(32'h0, 1, rd, resp, lat, stb);
      axi_write(32'h8, 32'hCAFEF00D, 4'hF, 0, 0, resp2, lat2, hs);
    join
    mdl_write(32'h8, 32'hCAFEF00D, 4'hF);
    chk("conc_rdata", rd, rd2);
    chk("conc_rresp", resp, 2'b00);
    chk("conc_bresp", resp2, 2'b00);
    axi_read(32'h8, 0, rd, resp, lat, stb);
    chk("conc_w_readback", rd, 32'hCAFEF00D);

    // randomized traffic, including unaligned and out-of-range addresses
    for (int it = 0; it < 30; it++) begin
      a = 32'($urandom_range(0, 23));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; st = 4'($urandom_range(0, 15));
        n0 = wen_cnt;
        axi_write(a, wd, st, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat, hs);
        chk("rnd_w_count", 128'(wen_cnt - n0), 128'(mdl_in(a)));
        chk("rnd_bresp", resp, mdl_resp(a));
        mdl_write(a, wd, st);
      end else begin
        axi_read(a, $urandom_range(0, 3), rd, resp, lat, stb);
        chk("rnd_rdata", rd, mdl_read(a));
        chk("rnd_rresp", resp, mdl_resp(a));
        chk("rnd_r_stable", 128'(stb), 1);
      end
    end

    // reset abort while holding only the AW half
    n0 = wen_cnt;
    s_axi_awaddr = 32'h0; s_axi_awvalid = 1;
    @(negedge clk);
    s_axi_awvalid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    bv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      bv_seen |= s_axi_bvalid;
    end
    chk("abort_no_w_en", 128'(wen_cnt - n0), 0);
    chk("abort_no_bvalid", 128'(bv_seen), 0);
    axi_read(32'h0, 0, rd, resp, lat, stb);
    chk("abort_readback", rd, mdl_read(32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_lite_ram_ctrl.md
# axi_lite_ram_ctrl

AXI4-Lite slave front-end for `Simple_RAM`. It accepts byte-addressed AXI4-Lite read and write transactions and converts them into single-cycle `r_en` and `w_en` accesses on the RAM's word-addressed ports, passing write strobes through. It sits directly upstream of `Simple_RAM`, between the system interconnect and the memory array.

## Interface
Parameters:
- `NUM_SLOTS`, 5, number of RAM words; must match `Simple_RAM`.
- `DATA_WIDTH_BYTES`, 4, bytes per word; must be a power of 2.
- `AXI_ADDR_WIDTH`, 32, width of the AXI byte address.
- Derived: `DATA_WIDTH_BITS = 8*DATA_WIDTH_BYTES`, `ADDR_WIDTH_BITS = $clog2(NUM_SLOTS)`, `BYTE_OFS = $clog2(DATA_WIDTH_BYTES)`.

Ports:
- `clk`, in, 1, single clock; all logic is on its rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- AW channel: `s_axi_awaddr` (in, `AXI_ADDR_WIDTH`), `s_axi_awvalid` (in, 1), `s_axi_awready` (out, 1).
- W channel: `s_axi_wdata` (in, `DATA_WIDTH_BITS`), `s_axi_wstrb` (in, `DATA_WIDTH_BYTES`), `s_axi_wvalid` (in, 1), `s_axi_wready` (out, 1).
- B channel: `s_axi_bresp` (out, 2), `s_axi_bvalid` (out, 1), `s_axi_bready` (in, 1).
- AR channel: `s_axi_araddr` (in, `AXI_ADDR_WIDTH`), `s_axi_arvalid` (in, 1), `s_axi_arready` (out, 1).
- R channel: `s_axi_rdata` (out, `DATA_WIDTH_BITS`), `s_axi_rresp` (out, 2), `s_axi_rvalid` (out, 1), `s_axi_rready` (in, 1).
- RAM write port: `ram_w_en` (out, 1), `ram_w_addr` (out, `ADDR_WIDTH_BITS`), `ram_w_data` (out, `DATA_WIDTH_BITS`), `ram_w_strb` (out, `DATA_WIDTH_BYTES`).
- RAM read port: `ram_r_en` (out, 1), `ram_r_addr` (out, `ADDR_WIDTH_BITS`), `ram_r_data` (in, `DATA_WIDTH_BITS`).

## Operation
- **Word index:** `addr >> BYTE_OFS`, computed at full width.
  - The low `BYTE_OFS` bits are ignored, so unaligned addresses are truncated.
  - The index is in range iff it is less than `NUM_SLOTS`.
- **RAM contract:**
  - A write commits at the rising edge that ends a cycle with `w_en=1`.
  - `ram_r_data` is valid in the cycle after a cycle with `r_en=1`.
- **Write FSM** (states `W_IDLE`, `W_HAVE_AW`, `W_HAVE_W`, `W_ISSUE`, `W_RESP`):
  - `W_IDLE`: `awready=wready=1`.
    - AW and W handshaking in the same cycle → `W_ISSUE`.
    - AW only → `W_HAVE_AW`.
    - W only → `W_HAVE_W`.
  - `W_HAVE_AW`: only `wready=1`; the W handshake → `W_ISSUE`.
  - `W_HAVE_W`: only `awready=1`; the AW handshake → `W_ISSUE`.
  - AW address, W data and W strobe are latched at their respective handshakes.
  - `W_ISSUE` (one cycle): `ram_w_en=1` if in range, otherwise 0. Always → `W_RESP`.
  - `W_RESP`: `bvalid=1`, `bresp` held stable. The `bready` handshake → `W_IDLE`.
- **Read FSM** (states `R_IDLE`, `R_ISSUE`, `R_WAIT`, `R_RESP`):
  - `R_IDLE`: `arready=1`; the handshake latches the address → `R_ISSUE`.
  - `R_ISSUE`: `ram_r_en=1` if in range → `R_WAIT`.
  - `R_WAIT`: `rdata` is loaded from `ram_r_data` (or 0 if out of range) → `R_RESP`.
  - `R_RESP`: `rvalid=1`, `rdata`/`rresp` held. The `rready` handshake → `R_IDLE`.
- **Channel independence:**
  - The read and write FSMs are independent and may access the RAM in the same cycle.
  - On a same-address collision the read returns the pre-write data; no ordering between channels is guaranteed.
- **Idle RAM signals:** `ram_*_addr/data/strb` hold their last values when the enables are low.
- **Reset:** asserting `rst_n` mid-transaction abandons it. No RAM access and no response are generated for it after release.

## Timing
- **Reset values:** every output is 0, including all readies.
  - The readies are registered and rise in the first cycle after `rst_n` deasserts.
- **Write latency:** completing the last of AW/W at edge k gives `ram_w_en` in cycle k+1 and `bvalid` from cycle k+2.
  - Minimum of 3 cycles per write.
- **Read latency:** the AR handshake at edge k gives `ram_r_en` in cycle k+1 and `rvalid` from cycle k+3.
  - Minimum of 4 cycles per read.
- **Handshake rules:**
  - `bvalid` and `rvalid` never depend combinationally on `bready`/`rready`.
  - `awready`, `wready` and `arready` are low in every state that does not accept the channel.
- `ram_w_en` and `ram_r_en` are always single-cycle pulses.

## Configuration
- `AXI_RAM_ERR_RESP_EN` defined:
  - Out-of-range accesses return `SLVERR` (2'b10).
- Not defined:
  - Out-of-range accesses return `OKAY` (2'b00).
  - Out-of-range writes are silently dropped and out-of-range reads return 0.
- In-range accesses always return `OKAY`, and the RAM is never accessed out of range in either configuration.

## Structure
- Package `axi_ram_pkg` holds:
  - The response constants `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10.
  - The write-state and read-state enum typedefs.
- Single module with no sub-module; the two FSMs are separate always blocks.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles, then release.
  - All outputs are 0 during reset.
  - `awready`, `wready` and `arready` are 1 in the first cycle after release.
  - No RAM enables fire.
- **Simultaneous AW/W write:** AW and W in the same cycle, awaddr=0x4, wdata=0x11223344, wstrb=4'b1101.
  - One `ram_w_en` pulse with addr=1, strb=4'b1101.
  - `bresp`=OKAY 2 cycles after the handshake.
- **Split write and byte-lane check:** W first (wdata=0x00003300, wstrb=4'b0010), AW 3 cycles later with awaddr=0x4.
  - `W_HAVE_W` is held for those 3 cycles, then exactly one write.
  - A subsequent read of 0x4 returns 0x11223344 with byte 1 replaced by 0x33.
- **Read with backpressure:** read of 0x4 with `rready` held low for 5 cycles.
  - `rvalid` rises 3 cycles after the AR handshake.
  - `rdata` stays stable until `rready`.
- **Out of range:** write and read at 0x14 (index 5).
  - No RAM enable fires.
  - `bresp`/`rresp` are `SLVERR` with `AXI_RAM_ERR_RESP_EN` defined, or `OKAY` with `rdata`=0 without it.
- **Concurrent channels and reset abort:**
  - A concurrent read of 0x0 and write of 0x8 both complete correctly.
  - Pulling `rst_n` low in `W_HAVE_AW` yields no `ram_w_en` and no `bvalid` afterwards.
